// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader and its UART receiver.
package imem_loader_pkg;

   localparam int DATA_BITS        = 8;
   localparam int STOP_BITS        = 1;
   localparam int DEF_CLKS_PER_BIT = 434;

   typedef enum logic [2:0] {
      S_LEN_HI = 3'd0,
      S_LEN_LO = 3'd1,
      S_DATA   = 3'd2,
      S_CHK    = 3'd3,
      S_FIN    = 3'd4
   } load_state_e;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_START = 2'd1,
      R_DATA  = 2'd2,
      R_STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte_valid / frame_err pulses.
module uart_rx
   import imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_o,
   output logic       frame_err_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   rx_state_e        state_q, state_d;
   logic [1:0]       sync_q;
   logic             prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             rx_s;

   assign rx_s = sync_q[1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= 2'b11;
         prev_q  <= 1'b1;
         state_q <= R_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rx_i};
         prev_q  <= rx_s;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         R_IDLE: begin
            if (prev_q && !rx_s) begin
               state_d = R_START;
               cnt_d   = '0;
            end
         end
         R_START: begin
            // A start bit that has gone high again by mid-bit was only a glitch.
            if (cnt_q == HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? R_IDLE : R_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         R_DATA: begin
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               if (bit_q == BIT_W'(DATA_BITS - 1)) state_d = R_STOP;
               else                                bit_d   = bit_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         R_STOP: begin
            if (cnt_q == FULL) begin
               state_d = R_IDLE;
               valid_d = rx_s;
               ferr_d  = !rx_s;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = R_IDLE;
      endcase
   end

   assign byte_valid_o = valid_q;
   assign byte_o       = shift_q;
   assign frame_err_o  = ferr_q;

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: UART frame -> 32-bit instruction-memory writes, holding the CPU in reset meanwhile.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int ADDR_W       = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err_frame,
   output logic              err_chk
);

   logic       rx_vld, rx_ferr;
   logic [7:0] rx_byte;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk_i        (clock),
      .rst_ni       (reset),
      .rx_i         (rx),
      .byte_valid_o (rx_vld),
      .byte_o       (rx_byte),
      .frame_err_o  (rx_ferr)
   );

   load_state_e       state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [1:0]        bidx_q, bidx_d;
   logic [31:0]       word_q, word_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_en_q, wr_en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_frame_q, err_frame_d;
   logic              end_load;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        acc_q, acc_d;
   logic              err_chk_q, err_chk_d;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_LEN_HI;
         len_q       <= '0;
         cnt_q       <= '0;
         bidx_q      <= '0;
         word_q      <= '0;
         addr_q      <= '0;
         wr_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_frame_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         acc_q       <= '0;
         err_chk_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         bidx_q      <= bidx_d;
         word_q      <= word_d;
         addr_q      <= addr_d;
         wr_en_q     <= wr_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_frame_q <= err_frame_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         acc_q       <= acc_d;
         err_chk_q   <= err_chk_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      bidx_d      = bidx_q;
      word_d      = word_q;
      addr_d      = addr_q;
      wr_en_d     = 1'b0;
      busy_d      = busy_q;
      done_d      = done_q;
      err_frame_d = err_frame_q;
      end_load    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_d       = acc_q;
      err_chk_d   = err_chk_q;
`endif
      if (rx_ferr) begin
         err_frame_d = 1'b1;
         busy_d      = 1'b0;
         state_d     = S_LEN_HI;
      end else begin
         case (state_q)
            S_LEN_HI: begin
               if (rx_vld) begin
                  len_d[15:8] = rx_byte;
                  busy_d      = 1'b1;
                  done_d      = 1'b0;
                  err_frame_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  err_chk_d   = 1'b0;
`endif
                  state_d     = S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (rx_vld) begin
                  len_d[7:0] = rx_byte;
                  cnt_d      = '0;
                  addr_d     = '0;
                  bidx_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  acc_d      = '0;
`endif
                  if ({len_q[15:8], rx_byte} == 16'd0) end_load = 1'b1;
                  else                                 state_d  = S_DATA;
               end
            end
            S_DATA: begin
               if (rx_vld) begin
                  word_d  = {word_q[23:0], rx_byte};
                  bidx_d  = bidx_q + 2'd1;
                  wr_en_d = (bidx_q == 2'd3);
`ifdef IMEM_LOADER_CHECKSUM_EN
                  acc_d   = acc_q ^ rx_byte;
`endif
               end
               // Address and count advance in the strobe cycle itself, so the strobe sees the old address.
               if (wr_en_q) begin
                  addr_d = addr_q + ADDR_W'(1);
                  cnt_d  = cnt_q + 16'd1;
                  if (cnt_q + 16'd1 == len_q) end_load = 1'b1;
               end
            end
            S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               if (rx_vld) begin
                  if (rx_byte == acc_q) begin
                     state_d = S_FIN;
                     done_d  = 1'b1;
                  end else begin
                     state_d   = S_LEN_HI;
                     err_chk_d = 1'b1;
                  end
                  busy_d = 1'b0;
               end
`else
               state_d = S_LEN_HI;
`endif
            end
            S_FIN:   state_d = S_LEN_HI;
            default: state_d = S_LEN_HI;
         endcase
      end
      if (end_load) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
         state_d = S_CHK;
`else
         state_d = S_FIN;
         done_d  = 1'b1;
         busy_d  = 1'b0;
`endif
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = addr_q;
   assign wr_data   = word_q;
   assign busy      = busy_q;
   assign cpu_hold  = busy_q;
   assign done      = done_q;
   assign err_frame = err_frame_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign err_chk   = err_chk_q;
`else
   assign err_chk   = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: UART byte driver, write scoreboard, flag checks at each step.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int CPB    = 32;
   localparam int ADDR_W = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              rx;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_hold, busy, done, err_frame, err_chk;

   int checks = 0;
   int errors = 0;

   logic [ADDR_W+31:0] exp_q[$];
   logic [ADDR_W-1:0]  exp_addr;
   logic [7:0]         chk_acc;
   logic               wr_en_prev = 1'b0;

   imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .rx        (rx),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .err_frame (err_frame),
      .err_chk   (err_chk)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Write-port monitor: every strobe must match the next scoreboard entry.
   always @(negedge clock) begin
      if (wr_en) begin
         check("wr_gap", 64'(wr_en_prev), 64'd0);
         check("wr_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            logic [ADDR_W+31:0] e;
            e = exp_q.pop_front();
            check("wr_addr", 64'(wr_addr), 64'(e[ADDR_W+31:32]));
            check("wr_data", 64'(wr_data), 64'(e[31:0]));
         end
      end
      wr_en_prev <= wr_en;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_bit();
      repeat (CPB) tick();
   endtask

   task automatic idle(input int bits);
      repeat (bits) wait_bit();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      wait_bit();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_bit();
      end
      rx = stop;
      wait_bit();
      rx = 1'b1;
   endtask

   task automatic start_load(input logic [15:0] n);
      chk_acc  = 8'h00;
      exp_addr = '0;
      send_byte(n[15:8], 1'b1);
      check("busy_on_len", 64'(busy), 64'd1);
      check("hold_on_len", 64'(cpu_hold), 64'd1);
      check("done_clr_on_len", 64'(done), 64'd0);
      check("ferr_clr_on_len", 64'(err_frame), 64'd0);
      send_byte(n[7:0], 1'b1);
   endtask

   task automatic send_word(input logic [31:0] w);
      exp_q.push_back({exp_addr, w});
      exp_addr = exp_addr + 1'b1;
      for (int i = 3; i >= 0; i--) begin
         logic [7:0] b;
         b = w[i*8 +: 8];
         chk_acc = chk_acc ^ b;
         send_byte(b, 1'b1);
      end
   endtask

   task automatic end_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(chk_acc, 1'b1);
`endif
      idle(1);
   endtask

   task automatic check_finished(input string tag);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
      check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
      check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
      check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
      check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_err_frame"}, 64'(err_frame), 64'd0);
      check({tag, "_err_chk"}, 64'(err_chk), 64'd0);
   endtask

   initial begin
      rx    = 1'b1;
      reset = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b1;
      idle(2);

      // Nominal two-word load
      start_load(16'd2);
      send_word(32'h12345678);
      check("hold_mid_load", 64'(cpu_hold), 64'd1);
      send_word(32'hDEADBEEF);
      end_load();
      check_finished("nominal");
      check("nominal_err_frame", 64'(err_frame), 64'd0);

      // Zero-length load
      start_load(16'd0);
      end_load();
      check_finished("zero_len");

      // Framing error on third payload byte
      start_load(16'd1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b0);
      idle(2);
      check("ferr_set", 64'(err_frame), 64'd1);
      check("ferr_busy", 64'(busy), 64'd0);
      check("ferr_hold", 64'(cpu_hold), 64'd0);
      check("ferr_done", 64'(done), 64'd0);
      start_load(16'd1);
      send_word(32'hAABBCCDD);
      end_load();
      check_finished("after_ferr");

      // Address wrap with a 4-word memory
      start_load(16'd5);
      for (int i = 0; i < 5; i++) send_word(32'(i));
      end_load();
      check_finished("wrap");

      // Short low glitch must not start a byte
      rx = 1'b0;
      repeat (10) tick();
      rx = 1'b1;
      idle(3);
      check("glitch_busy", 64'(busy), 64'd0);
      check("glitch_done", 64'(done), 64'd1);

      // Asynchronous reset in the middle of a load
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      check("midload_busy", 64'(busy), 64'd1);
      @(posedge clock);
      #3 reset = 1'b0;
      #1 check_all_zero("async_reset");
      tick();
      reset = 1'b1;
      idle(1);
      start_load(16'd1);
      send_word(32'hCAFEF00D);
      end_load();
      check_finished("after_reset");

`ifdef IMEM_LOADER_CHECKSUM_EN
      start_load(16'd1);
      send_word(32'h01020304);
      send_byte(8'h04, 1'b1);
      idle(1);
      check_finished("chk_good");
      check("chk_good_err", 64'(err_chk), 64'd0);
      start_load(16'd1);
      send_word(32'h01020304);
      send_byte(8'h05, 1'b1);
      idle(1);
      check("chk_bad_err", 64'(err_chk), 64'd1);
      check("chk_bad_done", 64'(done), 64'd0);
      check("chk_bad_busy", 64'(busy), 64'd0);
      check("chk_bad_drained", 64'(exp_q.size()), 64'd0);
`else
      check("err_chk_tied", 64'(err_chk), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Serial program loader: receives a framed program over a UART line and writes it, one 32-bit word per write, into the instruction memory's write port.
- It is the writer side of the instruction memory that the fetch stage reads.
- While a load is in progress it holds the processor in reset, so fetch never sees a partially written program.
- Sits beside the processor at the board top level; rx connects to the board UART RX pin.

Parameters:
- CLKS_PER_BIT, 434, system clocks per UART bit (50 MHz / 115200 baud).
- ADDR_W, 5, word-address width of the instruction memory write port.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  UART serial input, 8N1, idle high, asynchronous to clock.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  ADDR_W  word address of the current write.
- wr_data  out  32  word to write.
- cpu_hold  out  1  high while loading; ORed into the processor reset.
- busy  out  1  high from the first length byte until the load finishes or aborts.
- done  out  1  sticky; set at load completion, cleared when the next length byte arrives.
- err_frame  out  1  sticky framing error.
- err_chk  out  1  sticky checksum error; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, wr_addr=0, FSM in S_LEN_HI, receiver idle.
- rx path:
  - rx passes through a 2-flop synchronizer, which is the only latency before edge detection.
  - A falling edge in receiver idle starts a frame. The start bit is re-sampled at CLKS_PER_BIT/2; if it reads high, the frame is treated as a glitch and ignored.
  - Data bits are sampled every CLKS_PER_BIT, LSB first. The stop bit is sampled one bit later.
  - If the stop bit reads 1, byte_valid pulses for 1 cycle with the byte.
  - If the stop bit reads 0, the byte is dropped, err_frame is set, and the loader FSM aborts to S_LEN_HI: busy=0, cpu_hold=0, done stays 0.
- Frame format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - Then 4N payload bytes, each word MSB first.
  - Then CHK (only with the optional feature).
- FSM states: S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_FIN.
  - S_LEN_HI, on byte: latch length high byte; busy=1, cpu_hold=1, done=0, err_frame=0, err_chk=0; go to S_LEN_LO.
  - S_LEN_LO, on byte: latch N; reset word counter and wr_addr to 0, byte index to 0. If N==0, go to S_FIN (or S_CHK with the feature); otherwise go to S_DATA.
  - S_DATA, on byte: shift the byte into the word assembly register.
    - On the 4th byte, the next cycle drives wr_en=1 with wr_data = the assembled word and wr_addr = the current address.
    - After the strobe, wr_addr increments modulo 2^ADDR_W (N > 2^ADDR_W wraps and overwrites; no error) and the word counter increments.
    - When the counter reaches N, go to S_FIN (or S_CHK).
  - S_CHK: described under Optional Feature.
  - S_FIN: single cycle; done=1, busy=0, cpu_hold=0; return to S_LEN_HI.
- Timing guarantees:
  - wr_en is never asserted on two consecutive cycles; there is at most one write per 4 bytes.
  - wr_addr and wr_data are stable during the strobe cycle.
- Event ordering:
  - A byte_valid and a state transition in the same cycle: the byte is consumed by the current state.
  - Bytes that arrive in S_FIN are impossible, since S_FIN lasts 1 cycle and bytes are at least 10 bit-times apart.
- Reset mid-load: the load is abandoned, memory contents already written remain, and all flags clear.
- There is no inter-byte timeout; a stalled host leaves busy=1 until reset.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Each payload byte is XOR-accumulated. The accumulator clears in S_LEN_LO.
  - After the last payload byte the FSM enters S_CHK and waits for one byte.
  - If that byte equals the accumulator: go to S_FIN with done=1.
  - If it differs: err_chk=1, done stays 0, busy and cpu_hold drop, return to S_LEN_HI.
  - Words were already written before the check.
- Undefined: S_CHK is unreachable and err_chk is tied to 0.

Decomposition:
- Shared package:
  - FSM state encoding (S_LEN_HI..S_FIN).
  - UART constants: DATA_BITS=8, STOP_BITS=1.
  - Default CLKS_PER_BIT.
- One sub-module, uart_rx (synchronizer, bit timer, shift register, byte_valid/frame_err outputs), reused later for other serial inputs.
- The loader FSM, word assembly and address counter stay in imem_loader.

Test Plan:
- Nominal load: send 00 02 12 34 56 78 DE AD BE EF → wr_en twice: (addr 0, 0x12345678), (addr 1, 0xDEADBEEF); done=1; cpu_hold high from the first byte's stop bit until S_FIN.
- Zero length: send 00 00 → no wr_en; done=1 one cycle after LEN_LO.
- Framing error: stop bit forced 0 on the 3rd payload byte of a 1-word load → err_frame=1, no wr_en, busy=0; a following valid 00 01 AA BB CC DD clears err_frame and writes 0xAABBCCDD at addr 0.
- Wrap: ADDR_W=2, N=5, words 0..4 → writes to addrs 0,1,2,3,0; the 5th write has data 4.
- Glitch and reset: a 100-clock low pulse on rx produces no byte; reset asserted after 2 payload bytes → all outputs 0 asynchronously; the next load starts cleanly at addr 0.
- Checksum (macro defined): 00 01 01 02 03 04 then 04 → done=1. The same payload with CHK 05 → err_chk=1, done=0, and the word is still written.
